// File: rtl/rename_map_unit.sv
// N-wide register renamer: speculative and committed map tables plus a circular free list of physical tags.
// Optional single branch checkpoint is enabled by defining RENAME_CHECKPOINT_EN.
module rename_map_unit #(
  parameter int ARCH_REGS    = 34,
  parameter int PHYS_REGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  localparam int AREG_W = $clog2(ARCH_REGS),
  localparam int PREG_W = $clog2(PHYS_REGS)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic                             rn_valid_i,
  output logic                             rn_ready_o,
  input  logic [RENAME_WIDTH-1:0]          rn_we_i,
  input  logic [RENAME_WIDTH*AREG_W-1:0]   rn_src1_i,
  input  logic [RENAME_WIDTH*AREG_W-1:0]   rn_src2_i,
  input  logic [RENAME_WIDTH*AREG_W-1:0]   rn_dest_i,
  output logic [RENAME_WIDTH*PREG_W-1:0]   rn_psrc1_o,
  output logic [RENAME_WIDTH*PREG_W-1:0]   rn_psrc2_o,
  output logic [RENAME_WIDTH*PREG_W-1:0]   rn_pdest_o,
  output logic [RENAME_WIDTH*PREG_W-1:0]   rn_old_pdest_o,
  input  logic [COMMIT_WIDTH-1:0]          cm_we_i,
  input  logic [COMMIT_WIDTH*AREG_W-1:0]   cm_dest_i,
  input  logic [COMMIT_WIDTH*PREG_W-1:0]   cm_pdest_i,
  input  logic [COMMIT_WIDTH*PREG_W-1:0]   cm_old_pdest_i,
`ifdef RENAME_CHECKPOINT_EN
  input  logic                             ckpt_take_i,
  input  logic                             ckpt_restore_i,
  output logic                             ckpt_valid_o,
`endif
  output logic [PREG_W:0]                  free_count_o
);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] ptag_t;
  typedef logic [PREG_W:0]   ptr_t;

  ptag_t spec_map_q [ARCH_REGS];
  ptag_t spec_map_d [ARCH_REGS];
  ptag_t cmt_map_q  [ARCH_REGS];
  ptag_t cmt_map_d  [ARCH_REGS];
  ptag_t free_list_q [PHYS_REGS];
  ptr_t  head_q, head_d, tail_q, tail_d, chead_q, chead_d;
  ptr_t  free_cnt, alloc_n, cm_n;
  logic  fire, restore_hit;

  areg_t dest [RENAME_WIDTH];
  areg_t src1 [RENAME_WIDTH];
  areg_t src2 [RENAME_WIDTH];
  ptag_t pdest [RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0] alloc;

  logic [COMMIT_WIDTH-1:0] cm_v;
  ptr_t  cm_wptr [COMMIT_WIDTH];
  ptag_t cm_old  [COMMIT_WIDTH];

  // Youngest earlier allocating slot in the group overrides the speculative map.
  function automatic ptag_t lookup(input areg_t a, input int j);
    ptag_t p;
    p = (int'(a) < ARCH_REGS) ? spec_map_q[a] : '0;
    for (int i = 0; i < j; i++)
      if (alloc[i] && dest[i] == a) p = pdest[i];
    if (a == '0) p = '0;
    return p;
  endfunction

  always_comb begin
    alloc_n        = '0;
    alloc          = '0;
    rn_psrc1_o     = '0;
    rn_psrc2_o     = '0;
    rn_pdest_o     = '0;
    rn_old_pdest_o = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      dest[j]  = rn_dest_i[j*AREG_W +: AREG_W];
      src1[j]  = rn_src1_i[j*AREG_W +: AREG_W];
      src2[j]  = rn_src2_i[j*AREG_W +: AREG_W];
      alloc[j] = rn_we_i[j] && (dest[j] != '0);
      pdest[j] = alloc[j] ? free_list_q[ptag_t'(head_q + alloc_n)] : '0;
      if (alloc[j]) alloc_n = alloc_n + ptr_t'(1);
    end
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      rn_psrc1_o[j*PREG_W +: PREG_W]     = lookup(src1[j], j);
      rn_psrc2_o[j*PREG_W +: PREG_W]     = lookup(src2[j], j);
      rn_old_pdest_o[j*PREG_W +: PREG_W] = lookup(dest[j], j);
      rn_pdest_o[j*PREG_W +: PREG_W]     = pdest[j];
    end
  end

  always_comb begin
    areg_t cd;
    cmt_map_d = cmt_map_q;
    cm_n      = '0;
    cm_v      = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      cd         = cm_dest_i[k*AREG_W +: AREG_W];
      cm_v[k]    = cm_we_i[k] && (cd != '0);
      cm_wptr[k] = tail_q + cm_n;
      cm_old[k]  = cm_old_pdest_i[k*PREG_W +: PREG_W];
      if (cm_v[k]) begin
        if (int'(cd) < ARCH_REGS) cmt_map_d[cd] = cm_pdest_i[k*PREG_W +: PREG_W];
        cm_n = cm_n + ptr_t'(1);
      end
    end
    tail_d  = tail_q + cm_n;
    chead_d = chead_q + cm_n;
  end

  assign free_cnt     = tail_q - head_q;
  assign free_count_o = free_cnt;
  assign rn_ready_o   = !flush_i && !restore_hit && (free_cnt >= alloc_n);
  assign fire         = rn_valid_i && rn_ready_o;

`ifdef RENAME_CHECKPOINT_EN
  ptag_t ckpt_map_q [ARCH_REGS];
  ptag_t ckpt_map_d [ARCH_REGS];
  ptr_t  ckpt_head_q, ckpt_head_d;
  logic  ckpt_valid_q, ckpt_valid_d;
  assign restore_hit  = ckpt_restore_i && ckpt_valid_q;
  assign ckpt_valid_o = ckpt_valid_q;
`else
  assign restore_hit = 1'b0;
`endif

  always_comb begin
    spec_map_d = spec_map_q;
    head_d     = head_q;
`ifdef RENAME_CHECKPOINT_EN
    ckpt_map_d   = ckpt_map_q;
    ckpt_head_d  = ckpt_head_q;
    ckpt_valid_d = ckpt_valid_q;
`endif
    if (flush_i) begin
      spec_map_d = cmt_map_d;
      head_d     = chead_d;
`ifdef RENAME_CHECKPOINT_EN
      ckpt_valid_d = 1'b0;
    end else if (restore_hit) begin
      spec_map_d   = ckpt_map_q;
      head_d       = ckpt_head_q;
      ckpt_valid_d = 1'b0;
`endif
    end else if (fire) begin
      for (int j = 0; j < RENAME_WIDTH; j++)
        if (alloc[j] && int'(dest[j]) < ARCH_REGS) spec_map_d[dest[j]] = pdest[j];
      head_d = head_q + alloc_n;
`ifdef RENAME_CHECKPOINT_EN
      if (ckpt_take_i) begin
        ckpt_map_d   = spec_map_d;
        ckpt_head_d  = head_d;
        ckpt_valid_d = 1'b1;
      end
`endif
    end
  end

  // Only the initial fill region of the free list is reset; the rest is written by commits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_q[i] <= ptag_t'(i);
        cmt_map_q[i]  <= ptag_t'(i);
      end
      for (int i = 0; i < PHYS_REGS - ARCH_REGS; i++)
        free_list_q[i] <= ptag_t'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= ptr_t'(PHYS_REGS - ARCH_REGS);
      chead_q <= '0;
    end else begin
      spec_map_q <= spec_map_d;
      cmt_map_q  <= cmt_map_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      chead_q    <= chead_d;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (cm_v[k]) free_list_q[ptag_t'(cm_wptr[k])] <= cm_old[k];
    end
  end

`ifdef RENAME_CHECKPOINT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ckpt_valid_q <= 1'b0;
    else         ckpt_valid_q <= ckpt_valid_d;
  end

  always_ff @(posedge clk_i) begin
    ckpt_map_q  <= ckpt_map_d;
    ckpt_head_q <= ckpt_head_d;
  end
`endif

endmodule

// File: tb/tb_rename_map_unit.sv
// Self-checking bench for rename_map_unit: directed scenarios then randomized rename/commit/flush
// traffic checked against an in-order reference model with a simple ROB queue.
module tb_rename_map_unit;
  localparam int AR = 34, PR = 64, RW = 2, CW = 2, AW = 6, PW = 6;

  logic clk_i = 1'b0;
  logic reset_i, flush_i, rn_valid_i, rn_ready_o;
  logic [RW-1:0]    rn_we_i;
  logic [RW*AW-1:0] rn_src1_i, rn_src2_i, rn_dest_i;
  logic [RW*PW-1:0] rn_psrc1_o, rn_psrc2_o, rn_pdest_o, rn_old_pdest_o;
  logic [CW-1:0]    cm_we_i;
  logic [CW*AW-1:0] cm_dest_i;
  logic [CW*PW-1:0] cm_pdest_i, cm_old_pdest_i;
  logic [PW:0]      free_count_o;
`ifdef RENAME_CHECKPOINT_EN
  logic ckpt_take_i, ckpt_restore_i, ckpt_valid_o;
`endif

  rename_map_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .rn_valid_i(rn_valid_i), .rn_ready_o(rn_ready_o), .rn_we_i(rn_we_i),
    .rn_src1_i(rn_src1_i), .rn_src2_i(rn_src2_i), .rn_dest_i(rn_dest_i),
    .rn_psrc1_o(rn_psrc1_o), .rn_psrc2_o(rn_psrc2_o), .rn_pdest_o(rn_pdest_o),
    .rn_old_pdest_o(rn_old_pdest_o), .cm_we_i(cm_we_i), .cm_dest_i(cm_dest_i),
    .cm_pdest_i(cm_pdest_i), .cm_old_pdest_i(cm_old_pdest_i),
`ifdef RENAME_CHECKPOINT_EN
    .ckpt_take_i(ckpt_take_i), .ckpt_restore_i(ckpt_restore_i), .ckpt_valid_o(ckpt_valid_o),
`endif
    .free_count_o(free_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_total = 0;
  int we[RW], s1[RW], s2[RW], dd[RW];
  int cwe[CW], cd[CW], cp[CW], co[CW];
  bit v_b, f_b, take_b, rest_b;
  int m_spec[AR], m_cmt[AR], m_fl[PR], m_snap[AR];
  int m_head, m_tail, m_chead, m_snaph;
  bit m_cv;
  logic [31:0] o_ps1[RW], o_ps2[RW], o_pd[RW], o_old[RW], o_rdy, o_fc;
  int e_pd[RW], e_old[RW];
  bit e_alloc[RW];
  bit fired;
  typedef struct {int dest; int pd; int old; bit w;} rob_t;
  rob_t rob[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < AR; i++) begin m_spec[i] = i; m_cmt[i] = i; end
    for (int i = 0; i < PR - AR; i++) m_fl[i] = AR + i;
    m_head = 0; m_tail = PR - AR; m_chead = 0; m_cv = 0;
  endtask

  task automatic clear_in();
    for (int j = 0; j < RW; j++) begin we[j] = 0; s1[j] = 0; s2[j] = 0; dd[j] = 0; end
    for (int c = 0; c < CW; c++) begin cwe[c] = 0; cd[c] = 0; cp[c] = 0; co[c] = 0; end
    v_b = 0; f_b = 0; take_b = 0; rest_b = 0;
  endtask

  task automatic step(input string tag);
    int m[AR];
    int an, k, dup;
    bit rdy;
    for (int j = 0; j < RW; j++) begin
      rn_we_i[j] = (we[j] != 0);
      rn_src1_i[j*AW +: AW] = AW'(s1[j]);
      rn_src2_i[j*AW +: AW] = AW'(s2[j]);
      rn_dest_i[j*AW +: AW] = AW'(dd[j]);
    end
    for (int c = 0; c < CW; c++) begin
      cm_we_i[c] = (cwe[c] != 0);
      cm_dest_i[c*AW +: AW] = AW'(cd[c]);
      cm_pdest_i[c*PW +: PW] = PW'(cp[c]);
      cm_old_pdest_i[c*PW +: PW] = PW'(co[c]);
    end
    rn_valid_i = v_b; flush_i = f_b;
`ifdef RENAME_CHECKPOINT_EN
    ckpt_take_i = take_b; ckpt_restore_i = rest_b;
`endif
    #1;
    m = m_spec;
    an = 0;
    for (int j = 0; j < RW; j++) if (we[j] != 0 && dd[j] != 0) an++;
    rdy = !f_b && (m_tail - m_head) >= an;
`ifdef RENAME_CHECKPOINT_EN
    if (rest_b && m_cv) rdy = 0;
    chk({tag, ":ckpt_valid"}, {31'b0, ckpt_valid_o}, {31'b0, m_cv});
`endif
    o_rdy = {31'b0, rn_ready_o};
    o_fc  = {25'b0, free_count_o};
    chk({tag, ":ready"}, o_rdy, {31'b0, rdy});
    chk({tag, ":free_count"}, o_fc, m_tail - m_head);
    k = 0;
    for (int j = 0; j < RW; j++) begin
      o_ps1[j] = {26'b0, rn_psrc1_o[j*PW +: PW]};
      o_ps2[j] = {26'b0, rn_psrc2_o[j*PW +: PW]};
      o_pd[j]  = {26'b0, rn_pdest_o[j*PW +: PW]};
      o_old[j] = {26'b0, rn_old_pdest_o[j*PW +: PW]};
      e_alloc[j] = (we[j] != 0 && dd[j] != 0);
      e_old[j] = m[dd[j]];
      e_pd[j] = 0;
      if (e_alloc[j] && rdy) begin e_pd[j] = m_fl[(m_head + k) % PR]; k++; end
      if (rdy) begin
        chk({tag, ":psrc1"}, o_ps1[j], (s1[j] == 0) ? 0 : m[s1[j]]);
        chk({tag, ":psrc2"}, o_ps2[j], (s2[j] == 0) ? 0 : m[s2[j]]);
        chk({tag, ":old_pdest"}, o_old[j], e_old[j]);
        chk({tag, ":pdest"}, o_pd[j], e_pd[j]);
        if (e_alloc[j]) begin
          dup = 0;
          for (int r = 0; r < AR; r++) if (m_spec[r] == o_pd[j]) dup++;
          chk({tag, ":dup_tag"}, dup, 0);
          m[dd[j]] = e_pd[j];
        end
      end
    end
    fired = v_b && rdy;
    for (int c = 0; c < CW; c++)
      if (cwe[c] != 0 && cd[c] != 0) begin
        m_cmt[cd[c]] = cp[c];
        m_fl[m_tail % PR] = co[c];
        m_tail++; m_chead++;
      end
    if (f_b) begin
      m_spec = m_cmt; m_head = m_chead; m_cv = 0;
    end else if (rest_b && m_cv) begin
      m_spec = m_snap; m_head = m_snaph; m_cv = 0;
    end else if (fired) begin
      m_spec = m; m_head += an;
`ifdef RENAME_CHECKPOINT_EN
      if (take_b) begin m_snap = m; m_snaph = m_head; m_cv = 1; end
`endif
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    #1;
    model_reset();
    chk({tag, ":async_free_count"}, {25'b0, free_count_o}, 30);
    chk({tag, ":async_ready"}, {31'b0, rn_ready_o}, 1);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int nc;
    reset_i = 1'b1;
    clear_in();
    rn_valid_i = 0; flush_i = 0; rn_we_i = '0; rn_src1_i = '0; rn_src2_i = '0; rn_dest_i = '0;
    cm_we_i = '0; cm_dest_i = '0; cm_pdest_i = '0; cm_old_pdest_i = '0;
`ifdef RENAME_CHECKPOINT_EN
    ckpt_take_i = 0; ckpt_restore_i = 0;
`endif
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    clear_in(); s1[0] = 5; step("reset");
    chk("reset_psrc1_r5", o_ps1[0], 5);
    chk("reset_free_count", o_fc, 30);
    chk("reset_ready", o_rdy, 1);

    clear_in(); v_b = 1; we = '{1, 1}; dd = '{3, 4}; s1 = '{1, 3}; s2 = '{2, 3}; step("raw");
    chk("raw_pdest0", o_pd[0], 34);
    chk("raw_pdest1", o_pd[1], 35);
    chk("raw_psrc1_s1", o_ps1[1], 34);
    chk("raw_psrc2_s1", o_ps2[1], 34);
    chk("raw_old_s1", o_old[1], 4);
    clear_in(); s1 = '{3, 4}; step("raw_map");
    chk("map3", o_ps1[0], 34);
    chk("map4", o_ps1[1], 35);

    clear_in(); v_b = 1; we = '{1, 1}; dd = '{7, 7}; step("waw");
    chk("waw_old_s1", o_old[1], 36);
    chk("waw_pdest_s1", o_pd[1], 37);
    clear_in(); s1[0] = 7; step("waw_map");
    chk("waw_map7", o_ps1[0], 37);
    chk("waw_free_count", o_fc, 26);

    for (int i = 0; i < 12; i++) begin
      clear_in(); v_b = 1; we = '{1, 1}; dd = '{10, 11}; step("drain");
    end
    clear_in(); v_b = 1; we[0] = 1; dd[0] = 12; step("drain1");
    clear_in(); v_b = 1; we = '{1, 1}; dd = '{13, 14}; step("short");
    chk("short_free_count", o_fc, 1);
    chk("short_ready", o_rdy, 0);
    clear_in(); v_b = 1; we = '{1, 1}; dd = '{13, 0}; step("one_alloc");
    chk("one_alloc_ready", o_rdy, 1);
    chk("one_alloc_pdest0", o_pd[0], 63);
    chk("one_alloc_pdest1", o_pd[1], 0);
    clear_in(); step("empty");
    chk("empty_free_count", o_fc, 0);

    do_reset("midop");

    clear_in(); v_b = 1; we = '{1, 1}; dd = '{3, 4}; step("g1");
    clear_in(); v_b = 1; we = '{1, 1}; dd = '{5, 6}; step("g2");
    clear_in(); v_b = 1; we = '{1, 1}; dd = '{7, 8}; step("g3");
    clear_in(); f_b = 1; v_b = 1; we = '{1, 1}; dd = '{9, 10};
    cwe = '{1, 1}; cd = '{3, 4}; cp = '{34, 35}; co = '{3, 4}; step("flush");
    chk("flush_ready", o_rdy, 0);
    clear_in(); s1[0] = 3; s2[0] = 5; we[0] = 1; dd[0] = 9; step("post_flush");
    chk("flush_map3", o_ps1[0], 34);
    chk("flush_map5", o_ps2[0], 5);
    chk("flush_free_count", o_fc, 30);
    chk("flush_next_pdest", o_pd[0], 36);

`ifdef RENAME_CHECKPOINT_EN
    do_reset("ckpt");
    clear_in(); v_b = 1; we[0] = 1; dd[0] = 3; step("ck_g1");
    clear_in(); v_b = 1; we[0] = 1; dd[0] = 5; take_b = 1; step("ck_g2");
    clear_in(); v_b = 1; we[0] = 1; dd[0] = 3; step("ck_g3");
    clear_in(); v_b = 1; we[0] = 1; dd[0] = 6; rest_b = 1; step("ck_restore");
    chk("ck_restore_ready", o_rdy, 0);
    clear_in(); s1[0] = 3; we[0] = 1; dd[0] = 9; step("ck_post");
    chk("ck_map3", o_ps1[0], 34);
    chk("ck_next_pdest", o_pd[0], 36);
`endif

    do_reset("rand");
    rob.delete();
    for (int c = 0; c < 500; c++) begin
      clear_in();
      v_b = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < RW; j++) begin
        we[j] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        dd[j] = $urandom_range(0, AR - 1);
        s1[j] = $urandom_range(0, AR - 1);
        s2[j] = $urandom_range(0, AR - 1);
      end
      nc = $urandom_range(0, CW);
      if (nc > rob.size()) nc = rob.size();
      for (int q = 0; q < CW; q++) begin
        if (q < nc) begin
          cwe[q] = rob[q].w ? 1 : 0; cd[q] = rob[q].dest; cp[q] = rob[q].pd; co[q] = rob[q].old;
        end else begin
          cwe[q] = 0; cd[q] = $urandom_range(1, AR - 1); cp[q] = $urandom_range(0, PR - 1);
          co[q] = $urandom_range(0, PR - 1);
        end
      end
      f_b = ($urandom_range(0, 31) == 0);
      step("rand");
      for (int q = 0; q < nc; q++) rob.delete(0);
      if (f_b) rob.delete();
      else if (fired)
        for (int j = 0; j < RW; j++) rob.push_back('{dd[j], e_pd[j], e_old[j], e_alloc[j]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
